// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 1-to-4 registered demultiplexer.
package demux_pkg;
    localparam int NUM_OUT    = 4;
    localparam int SEL_W      = 2;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/dec_2to4.sv
// dec_2to4: combinational 2-to-4 one-hot decoder, all-zero when disabled.
module dec_2to4
    import demux_pkg::*;
(
    input  logic               en_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] y_o
);
    always_comb y_o = en_i ? {{(NUM_OUT-1){1'b0}}, 1'b1} << sel_i : '0;
endmodule

// File: rtl/demux_1to4.sv
// demux_1to4: routes in to one of four registered outputs with a one-hot strobe.
// Unselected outputs clear on a transfer when ZERO_UNSEL=1, otherwise they hold.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit ZERO_UNSEL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [NUM_OUT-1:0] out_valid
);
    logic [NUM_OUT-1:0]             valid_d, valid_q;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_d, out_q;

    // Decoder output doubles as per-lane write enable and next strobe.
    dec_2to4 u_dec (
        .en_i  (in_valid),
        .sel_i (sel),
        .y_o   (valid_d)
    );

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++)
            out_d[k] = valid_d[k] ? in : (in_valid && ZERO_UNSEL) ? '0 : out_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = valid_q;
endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: directed checks of both ZERO_UNSEL variants driven in parallel.
module tb_demux_1to4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] z0, z1, z2, z3, h0, h1, h2, h3;
    logic [3:0] zv, hv;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    demux_1to4 #(.DATA_W(8), .ZERO_UNSEL(1'b1)) u_z (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
        .out0(z0), .out1(z1), .out2(z2), .out3(z3), .out_valid(zv)
    );
    demux_1to4 #(.DATA_W(8), .ZERO_UNSEL(1'b0)) u_h (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
        .out0(h0), .out1(h1), .out2(h2), .out3(h3), .out_valid(hv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_z(input string tag, input logic [7:0] e0, e1, e2, e3, input logic [3:0] ev);
        chk({tag, " z.out0"}, 32'(z0), 32'(e0));
        chk({tag, " z.out1"}, 32'(z1), 32'(e1));
        chk({tag, " z.out2"}, 32'(z2), 32'(e2));
        chk({tag, " z.out3"}, 32'(z3), 32'(e3));
        chk({tag, " z.valid"}, 32'(zv), 32'(ev));
    endtask

    task automatic chk_h(input string tag, input logic [7:0] e0, e1, e2, e3, input logic [3:0] ev);
        chk({tag, " h.out0"}, 32'(h0), 32'(e0));
        chk({tag, " h.out1"}, 32'(h1), 32'(e1));
        chk({tag, " h.out2"}, 32'(h2), 32'(e2));
        chk({tag, " h.out3"}, 32'(h3), 32'(e3));
        chk({tag, " h.valid"}, 32'(hv), 32'(ev));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic v);
        in = d;
        sel = s;
        in_valid = v;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(8'hC3, 2'd2, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_z("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_h("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick();
        chk_z("rst_held", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        rst_n = 1'b1;

        drive(8'hFF, 2'd0, 1'b1); tick();
        chk_z("ff_s0", 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0001);
        chk_h("ff_s0", 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0001);
        drive(8'hAA, 2'd1, 1'b1); tick();
        chk_z("aa_s1", 8'h00, 8'hAA, 8'h00, 8'h00, 4'b0010);
        chk_h("aa_s1", 8'hFF, 8'hAA, 8'h00, 8'h00, 4'b0010);
        drive(8'h55, 2'd2, 1'b1); tick();
        chk_z("55_s2", 8'h00, 8'h00, 8'h55, 8'h00, 4'b0100);
        chk_h("55_s2", 8'hFF, 8'hAA, 8'h55, 8'h00, 4'b0100);
        drive(8'h33, 2'd3, 1'b1); tick();
        chk_z("33_s3", 8'h00, 8'h00, 8'h00, 8'h33, 4'b1000);
        chk_h("33_s3", 8'hFF, 8'hAA, 8'h55, 8'h33, 4'b1000);

        drive(8'h77, 2'd1, 1'b0); tick();
        chk_z("idle", 8'h00, 8'h00, 8'h00, 8'h33, 4'b0000);
        chk_h("idle", 8'hFF, 8'hAA, 8'h55, 8'h33, 4'b0000);

        drive(8'hFF, 2'd0, 1'b1); tick();
        drive(8'hAA, 2'd1, 1'b1); tick();
        chk_z("pre_rst", 8'h00, 8'hAA, 8'h00, 8'h00, 4'b0010);
        drive(8'h55, 2'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_z("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_h("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        tick();
        chk_h("rst_discard", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk_z("post_rst", 8'h00, 8'h00, 8'h55, 8'h00, 4'b0100);
        chk_h("post_rst", 8'h00, 8'h00, 8'h55, 8'h00, 4'b0100);

        drive(8'h12, 2'd0, 1'b1);
        #3 sel = 2'd3;
        #3 sel = 2'd1;
        tick();
        chk_z("sel_toggle", 8'h00, 8'h12, 8'h00, 8'h00, 4'b0010);
        chk_h("sel_toggle", 8'h00, 8'h12, 8'h55, 8'h00, 4'b0010);
        sel = 2'd2;
        #3;
        chk_z("sel_between", 8'h00, 8'h12, 8'h00, 8'h00, 4'b0010);

        drive(8'h81, 2'd3, 1'b1); tick();
        chk_z("msb_lsb", 8'h00, 8'h00, 8'h00, 8'h81, 4'b1000);
        chk_h("msb_lsb", 8'h00, 8'h12, 8'h55, 8'h81, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
